// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one request at a time, internal RAM or external req/ack bus.
// Optional build macro MEM_TIMEOUT_EN adds an external-ack timeout with an ERR completion state.
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1730,
  parameter int unsigned INT_DEPTH = 1024,
  parameter int unsigned INT_LAT   = 1,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned IAW      = $clog2(INT_DEPTH)
) (
  input  logic           Clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           we,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    dec_addr,
  input  logic           cs,
  output logic           int_en,
  output logic           int_we,
  output logic [IAW-1:0] int_addr,
  output logic [31:0]    int_wdata,
  input  logic [31:0]    int_rdata,
  output logic           ext_req,
  output logic           ext_we,
  output logic [31:0]    ext_addr,
  output logic [31:0]    ext_wdata,
  input  logic [31:0]    ext_rdata,
  input  logic           ext_ack,
  output logic [31:0]    rdata,
  output logic           done,
  output logic           busy,
  output logic           err
);

  if (INT_LAT < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mem_access_ctrl: INT_LAT and TIMEOUT must be at least 1");
  end

  localparam int unsigned LCW = $clog2(INT_LAT + 1);
  localparam logic [LCW-1:0] LatFirst = LCW'(INT_LAT - 1);

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StDecode, StIntAcc, StExtAcc, StDone, StErr} state_e;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;
`else
  typedef enum logic [2:0] {StIdle, StDecode, StIntAcc, StExtAcc, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            rdata_ld;
  logic [LCW-1:0]  lat_q, lat_d;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
      if (state_q == StIdle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (rdata_ld) rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rdata_ld = 1'b0;
    rdata_d  = rdata_q;
    int_en   = 1'b0;
    int_we   = 1'b0;
    ext_req  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StDecode;
      end
      StDecode: begin
        if (cs) begin
          state_d = StExtAcc;
`ifdef MEM_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          state_d = StIntAcc;
          lat_d   = LatFirst;
        end
      end
      StIntAcc: begin
        int_en = 1'b1;
        // Write only on the first cycle so multi-cycle RAMs see a single store.
        int_we = we_q && (lat_q == LatFirst);
        if (lat_q == '0) begin
          rdata_ld = !we_q;
          rdata_d  = int_rdata;
          state_d  = StDone;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StExtAcc: begin
        ext_req = 1'b1;
        // An ack on the expiry edge takes priority over the timeout.
        if (ext_ack) begin
          rdata_ld = !we_q;
          rdata_d  = ext_rdata;
          state_d  = StDone;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          rdata_ld = 1'b1;
          rdata_d  = '0;
          state_d  = StErr;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
`ifdef MEM_TIMEOUT_EN
      StErr: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign dec_addr  = (state_q == StIdle) ? addr : addr_q;
  assign int_addr  = IAW'(addr_q - BASE_ADDR);
  assign int_wdata = wdata_q;
  assign ext_we    = ext_req & we_q;
  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized accesses against
// a transaction-level reference model; honours MEM_TIMEOUT_EN when defined.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE    = 32'h0000_1730;
  localparam int          DEPTH   = 1024;
  localparam int          INT_LAT = 1;
  localparam int          TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] dec_addr;
  logic        cs;
  logic        int_en, int_we;
  logic [9:0]  int_addr;
  logic [31:0] int_wdata, int_rdata;
  logic        ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [31:0] rdata;
  logic        done, busy, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [DEPTH];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;

  always #5 Clk = ~Clk;

  mem_access_ctrl dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .dec_addr  (dec_addr),
    .cs        (cs),
    .int_en    (int_en),
    .int_we    (int_we),
    .int_addr  (int_addr),
    .int_wdata (int_wdata),
    .int_rdata (int_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  // Address decoder stub: registered, internal window is [BASE, BASE+DEPTH).
  always @(posedge Clk or negedge rst_n) begin
    if (!rst_n) cs <= 1'b0;
    else        cs <= ((dec_addr - BASE) >= 32'(DEPTH));
  end

  // Internal RAM stub with combinational read.
  assign int_rdata = ram[int_addr];
  always @(posedge Clk) if (int_en && int_we) ram[int_addr] <= int_wdata;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit is_int(input logic [31:0] a);
    return (a - BASE) < 32'(DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full access; ack_dly = number of ext_req cycles before ack (0 = never ack).
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int ack_dly, input logic [31:0] xd, input bit hold);
    bit          internal;
    bit          exp_err;
    int          idx, exp_ext, exp_lat, exp_we, k, n_ext, n_we;
    logic [31:0] seen_iaddr;
    internal   = is_int(a);
    idx        = int'((a - BASE) % 32'(DEPTH));
    exp_err    = 1'b0;
    exp_we     = 0;
    seen_iaddr = 32'hFFFF_FFFF;
    if (internal) begin
      exp_ext = 0;
      exp_lat = 1 + INT_LAT;
      if (w) begin
        exp_we       = 1;
        ref_mem[idx] = d;
      end else begin
        last_rd = ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
      end
    end else begin
`ifdef MEM_TIMEOUT_EN
      if (ack_dly == 0 || ack_dly > TIMEOUT) begin
        exp_err = 1'b1;
        exp_ext = TIMEOUT;
        last_rd = 32'h0;
      end else
`endif
      begin
        exp_ext = ack_dly;
        if (!w) last_rd = xd;
      end
      exp_lat = 1 + exp_ext;
    end

    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge Clk);
    @(negedge Clk);
    if (!hold) req = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    k = 0; n_ext = 0; n_we = 0;
    while (!done && k < 64) begin
      if (ext_req) begin
        n_ext++;
        ext_ack   = (n_ext == ack_dly);
        ext_rdata = ext_ack ? xd : ~xd;
      end else begin
        ext_ack = 1'b0;
      end
      if (int_en) begin
        if (int_we) n_we++;
        seen_iaddr = 32'(int_addr);
      end
      @(negedge Clk);
      k++;
    end
    ext_ack = 1'b0;
    chk("done_latency", k, exp_lat);
    chk("done_seen", done, 1'b1);
    chk("err", err, exp_err);
    chk("rdata", rdata, last_rd);
    chk("ext_req_cycles", n_ext, exp_ext);
    chk("int_we_cycles", n_we, exp_we);
    chk("ext_req_at_done", ext_req, 1'b0);
    if (internal) chk("int_addr", seen_iaddr, 32'(idx));
    @(negedge Clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int          sel, dly;
    bit          w, hold;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ext_ack = 1'b0; ext_rdata = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ext_req", ext_req, 1'b0);
    chk("rst_int_en", int_en, 1'b0);
    chk("rst_int_we", int_we, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge Clk);

    // Stray ack while idle must not start anything.
    ext_ack = 1'b1;
    @(negedge Clk);
    ext_ack = 1'b0;
    chk("stray_ack_idle", busy, 1'b0);

    access(1'b1, 32'h0000_1730, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    access(1'b0, 32'h0000_1730, 32'h0, 1, 32'h0, 1'b0);
    chk("load_first_word", rdata, 32'hDEAD_BEEF);
    access(1'b1, 32'h0000_1B2F, 32'h1234_5678, 1, 32'h0, 1'b0);
    chk("store_keeps_rdata", rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_1B2F, 32'h0, 1, 32'h0, 1'b0);
    access(1'b0, 32'h0000_1B30, 32'h0, 3, 32'hA5A5_A5A5, 1'b0);
    chk("ext_load", rdata, 32'hA5A5_A5A5);
    access(1'b0, 32'h0000_0000, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    access(1'b0, BASE - 32'd1, 32'h0, 2, 32'h5555_AAAA, 1'b0);
    access(1'b1, 32'hFFFF_FFF0, 32'h7777_0000, 20, 32'h0, 1'b0);

    // req held through DONE: second access only after an IDLE cycle.
    access(1'b0, 32'h0000_1731, 32'h0, 1, 32'h0, 1'b1);
    access(1'b0, 32'h0000_1731, 32'h0, 1, 32'h0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    access(1'b0, 32'h0000_2000, 32'h0, 0, 32'h0, 1'b0);
    chk("timeout_rdata_zero", rdata, 32'h0);
    access(1'b0, 32'h0000_2000, 32'h0, TIMEOUT, 32'h1357_9BDF, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      sel  = int'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      dly  = int'($urandom_range(1, 5));
      hold = ($urandom_range(0, 7) == 0);
      if (sel < 2)       a = BASE + 32'($urandom_range(0, DEPTH - 1));
      else if (sel == 2) a = BASE + 32'(DEPTH) + 32'($urandom_range(0, 1000));
      else               a = BASE - 32'd1 - 32'($urandom_range(0, 3));
      access(w, a, $urandom, dly, $urandom, hold);
    end
    req = 1'b0;
    @(negedge Clk);

    // Reset in the middle of an external access.
    access(1'b0, 32'h0000_1740, 32'h0, 1, 32'h0, 1'b0);
    req = 1'b1; we = 1'b0; addr = 32'h0000_4000;
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("ext_req_before_reset", ext_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ext_req", ext_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_rdata", rdata, 32'h0);
    last_rd = 32'h0;
    @(negedge Clk);
    rst_n = 1'b1;
    @(negedge Clk);
    chk("post_reset_idle", busy, 1'b0);
    chk("post_reset_no_done", done, 1'b0);
    access(1'b0, 32'h0000_1730, 32'h0, 1, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
